// File: rtl/scytale_decryption.sv
// Scytale decryption stage: buffers ciphertext until the start token, then
// streams the plaintext one byte per cycle using the keys latched at the token.
module scytale_decryption #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
  // Wide enough for (MAX_NOF_CHARS-1) + max key_N without wrapping.
  localparam int CALC_W = $clog2(MAX_NOF_CHARS + (1 << KEY_WIDTH));
  localparam int PROD_W = 2 * KEY_WIDTH;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     n_q;
  logic [CNT_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [KEY_WIDTH-1:0] key_n_q;
  logic                 scy_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [D_WIDTH-1:0]   data_q;
  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

  logic              accept;
  logic              is_token;
  logic              store_en;
  logic              scy_ok;
  logic [PROD_W-1:0] prod;
  logic [CALC_W-1:0] idx_sum;
  logic [CALC_W-1:0] last_idx;
  logic [CALC_W-1:0] idx_step;
  logic [CNT_W-1:0]  idx_d;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    accept   = 1'b0;
    is_token = 1'b0;
    store_en = 1'b0;
    prod     = '0;
    scy_ok   = 1'b0;
    idx_sum  = '0;
    last_idx = '0;
    idx_step = '0;

    accept   = (state_q == COLLECT) && valid_i;
    is_token = (data_i == START_DECRYPTION_TOKEN);
    store_en = accept && !is_token && (n_q < CNT_W'(MAX_NOF_CHARS));

    prod   = PROD_W'(key_N) * PROD_W'(key_M);
    scy_ok = (key_N != '0) && (key_M != '0) && (prod == PROD_W'(n_q));

    // Column walk: step by key_N, wrapping back to the next column start.
    idx_sum  = CALC_W'(idx_q) + CALC_W'(key_n_q);
    last_idx = CALC_W'(n_q) - CALC_W'(1);
    if (scy_q) begin
      idx_step = (idx_sum <= last_idx) ? idx_sum : (idx_sum - last_idx);
    end else begin
      idx_step = CALC_W'(idx_q) + CALC_W'(1);
    end
  end

  assign idx_d = CNT_W'(idx_step);

  // NOTE: the character buffer has no reset; its contents are only read below n_q.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[n_q] <= data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      n_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      key_n_q <= '0;
      scy_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          valid_q <= 1'b0;
          data_q  <= '0;
          if (store_en) begin
            n_q <= n_q + CNT_W'(1);
          end
          if (accept && is_token) begin
            key_n_q <= key_N;
            scy_q   <= scy_ok;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (cnt_q < n_q) begin
            valid_q <= 1'b1;
            data_q  <= mem_q[idx_q];
            idx_q   <= idx_d;
            cnt_q   <= cnt_q + CNT_W'(1);
          end else begin
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            n_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
